// File: rtl/bram_byte_arbiter.sv
// rtl/bram_byte_arbiter.sv - two-requester round-robin byte arbiter and zero-fill sequencer for a 1KB BRAM tile
module bram_byte_arbiter #(
    parameter int RD_TOP_LSB = 24,
    parameter int WR_TOP_LSB = 16,
    parameter int WE_BIT     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic        a_we,
    input  logic [9:0]  a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_rvalid,
    output logic [7:0]  a_rdata,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic        b_we,
    input  logic [9:0]  b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_rvalid,
    output logic [7:0]  b_rdata,
    input  logic        init_start,
    output logic        init_busy,
    output logic        init_done,
    output logic [7:0]  bram_rd_addr,
    output logic [7:0]  bram_wr_addr,
    output logic [31:0] bram_wr_data,
    input  logic [31:0] bram_rd_data,
    output logic [5:0]  bram_cfg
);

    typedef enum logic {SERVE, INIT} state_t;

    state_t      state_q, state_d;
    logic        last_b_q;
    logic [9:0]  cnt_q;
    logic        tag1_v, tag1_b, tag2_v, tag2_b;
    logic [7:0]  rd_addr_q, wr_addr_q, wdata_q;
    logic [1:0]  rtop_q, wtop_q;
    logic        we_q;
    logic        done_q;
    logic        grant_a, grant_b, accept;
    logic        sel_we;
    logic [9:0]  sel_addr;
    logic [7:0]  sel_wdata;
    logic        unused_rd_bits;

    assign bram_cfg       = 6'b000101;
    assign init_busy      = (state_q == INIT);
    assign init_done      = done_q;
    assign bram_rd_addr   = rd_addr_q;
    assign bram_wr_addr   = wr_addr_q;
    assign unused_rd_bits = ^bram_rd_data[31:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SERVE;
        else     state_q <= state_d;
    end

    // Ties go to the requester that did not win last time.
    always_comb begin
        state_d = state_q;
        grant_a = 1'b0;
        grant_b = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state_q)
            SERVE: begin
                grant_a = a_valid && (!b_valid || last_b_q);
                grant_b = b_valid && (!a_valid || !last_b_q);
                a_ready = grant_a;
                b_ready = grant_b;
                if (init_start) state_d = INIT;
            end
            INIT: begin
                if (cnt_q == 10'h3FF) state_d = SERVE;
            end
            default: state_d = SERVE;
        endcase
    end

    assign accept    = a_ready || b_ready;
    assign sel_we    = b_ready ? b_we    : a_we;
    assign sel_addr  = b_ready ? b_addr  : a_addr;
    assign sel_wdata = b_ready ? b_wdata : a_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b_q  <= 1'b1;
            cnt_q     <= '0;
            tag1_v    <= 1'b0;
            tag1_b    <= 1'b0;
            tag2_v    <= 1'b0;
            tag2_b    <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wdata_q   <= '0;
            rtop_q    <= '0;
            wtop_q    <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            we_q   <= 1'b0;
            tag1_v <= 1'b0;
            done_q <= (state_q == INIT) && (cnt_q == 10'h3FF);
            if (state_q == INIT) begin
                // Counter wraps to 0 after the last address, leaving it clear for the next fill.
                wr_addr_q <= cnt_q[7:0];
                wtop_q    <= cnt_q[9:8];
                wdata_q   <= 8'h00;
                we_q      <= 1'b1;
                cnt_q     <= cnt_q + 10'd1;
            end else if (accept) begin
                last_b_q <= b_ready;
                if (sel_we) begin
                    wr_addr_q <= sel_addr[7:0];
                    wtop_q    <= sel_addr[9:8];
                    wdata_q   <= sel_wdata;
                    we_q      <= 1'b1;
                end else begin
                    rd_addr_q <= sel_addr[7:0];
                    rtop_q    <= sel_addr[9:8];
                    tag1_v    <= 1'b1;
                    tag1_b    <= b_ready;
                end
            end
            tag2_v   <= tag1_v;
            tag2_b   <= tag1_b;
            a_rvalid <= tag2_v && !tag2_b;
            b_rvalid <= tag2_v && tag2_b;
            if (tag2_v && !tag2_b) a_rdata <= bram_rd_data[7:0];
            if (tag2_v && tag2_b)  b_rdata <= bram_rd_data[7:0];
        end
    end

    always_comb begin
        bram_wr_data                     = '0;
        bram_wr_data[7:0]                = wdata_q;
        bram_wr_data[WR_TOP_LSB +: 2]    = wtop_q;
        bram_wr_data[WE_BIT]             = we_q;
        bram_wr_data[RD_TOP_LSB +: 2]    = rtop_q;
    end

endmodule

// File: doc/bram_byte_arbiter.md
# bram_byte_arbiter

Two-requester round-robin arbiter and initialiser for one BlockRAM_1KB tile operated in byte mode (1024 x 8 bit). It multiplexes byte read/write requests from two fabric-side masters onto the tile's rd_addr/wr_addr/wr_data port. It packs the upper address bits and write enable into the wr_data control-bit positions the tile expects. It also provides a hardware clear sequencer that zero-fills the whole RAM after reset or on command.

## Interface
- RD_TOP_LSB, 24: wr_data bit position of read-address bits [9:8].
- WR_TOP_LSB, 16: wr_data bit position of write-address bits [9:8].
- WE_BIT, 20: wr_data bit carrying the active-high dynamic write enable.
- clk  in  1  single clock; also drives the BRAM tile.
- rst  in  1  reset, asynchronous, active-high.
- a_valid / b_valid  in  1  request present.
- a_ready / b_ready  out  1  request accepted this cycle; combinational grant.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_addr / b_addr  in  10  byte address.
- a_wdata / b_wdata  in  8  write byte.
- a_rvalid / b_rvalid  out  1  one-cycle pulse: read data valid.
- a_rdata / b_rdata  out  8  read byte; held until the next pulse to that requester.
- init_start  in  1  start a zero-fill of all 1024 bytes.
- init_busy  out  1  zero-fill in progress.
- init_done  out  1  one-cycle pulse after the last fill write is issued.
- bram_rd_addr  out  8  to tile rd_addr; read address bits [7:0].
- bram_wr_addr  out  8  to tile wr_addr; write address bits [7:0].
- bram_wr_data  out  32  to tile wr_data: [7:0] = data, [WR_TOP_LSB+1:WR_TOP_LSB] = write addr[9:8], [WE_BIT] = write enable, [RD_TOP_LSB+1:RD_TOP_LSB] = read addr[9:8], all other bits 0.
- bram_rd_data  in  32  from tile rd_data; only [7:0] is used.
- bram_cfg  out  6  constant {C5..C0} = 6'b000101: byte write, byte read, dynamic write enable, no output register.

## Operation
- States: SERVE, INIT. Reset enters SERVE.
- **SERVE, grant rules:**
  - One operation is granted per cycle.
  - A lone valid requester is granted.
  - If both requesters are valid, the one not granted last wins.
  - The last-grant pointer resets to B, so A wins the first tie.
  - x_ready = grant && !init_busy. Ready is never asserted without valid.
- **SERVE, issue:**
  - An accepted op is registered onto the BRAM outputs at the accepting edge.
  - A write drives wr_addr = addr[7:0], write top bits = addr[9:8], data, and WE_BIT = 1.
  - A read drives rd_addr = addr[7:0], read top bits = addr[9:8], and WE_BIT = 0.
  - Fields of the non-selected port keep their previous values.
  - In a cycle with no grant, WE_BIT is 0.
- **Read return:**
  - A 2-entry shift of {valid, requester-id} tracks in-flight reads.
  - bram_rd_data[7:0] is registered into x_rdata when the tag reaches stage 2.
  - x_rvalid pulses in that same cycle.
  - Reads complete in issue order. At most 3 reads are in flight; no back-pressure on returns.
- **INIT:**
  - init_start while in SERVE moves to INIT on the next edge. A request handshaking in that same cycle is still accepted and executed.
  - init_start while in INIT is ignored.
  - In INIT, a 10-bit counter issues writes of 0x00 to addresses 0..1023, one per cycle, with WE_BIT = 1.
  - After address 1023: pulse init_done, return to SERVE, clear the counter.
  - Reads in flight at INIT entry still return normally.
- **Reset:**
  - Asserting rst, including mid-INIT, aborts everything and returns to SERVE with counter 0.
  - No init_done pulse is produced on abort.
  - In-flight read tags are discarded.

## Timing
- Reset values:
  - all ready, rvalid and init_done low; init_busy low;
  - rdata 0; bram_rd_addr, bram_wr_addr and bram_wr_data 0;
  - bram_cfg constant.
- Write: accepted in cycle N; the BRAM commits at the end of cycle N+1.
- Read: accepted in cycle N; the BRAM samples at the end of N+1; tile data is valid in N+2; x_rvalid/x_rdata are valid in cycle N+3.
- Read-after-write: a read of the same address accepted one cycle after a write returns the new byte.
- Sustained throughput: 1 op/cycle. Alternating grants under continuous contention.
- init_busy is high from the cycle after init_start through the cycle of the last fill write.
- init_done is high in the cycle after the last fill write; total fill time is 1024 cycles.

## Test plan
- **Single requester:** A writes 0x5A to 0x3FF, then reads 0x3FF. Required: bram_wr_data[17:16] = 2'b11 and bit 20 = 1 in the write issue cycle; a_rvalid exactly 3 cycles after the read handshake with a_rdata = 0x5A.
- **Contention:** A and B both valid with reads to 0x001 and 0x102 for 4 cycles. Required: grants in order A, B, A, B; rvalid pulses return in the same order with the correct bytes; bram_wr_data[25:24] = 0, 1, 0, 1.
- **Init:** preload 0xFF at 0x000, 0x200 and 0x3FF; pulse init_start. Required: init_busy for exactly 1024 cycles, no ready during that window, init_done one pulse; subsequent reads return 0x00.
- **Simultaneous events:** init_start in the same cycle as an accepted A read. Required: the read returns the pre-fill byte at N+3 while INIT proceeds; a second init_start mid-fill changes nothing.
- **Reset mid-INIT:** assert rst at fill address 500. Required: all outputs at reset values, no init_done, SERVE after release; a fresh init_start runs a full 1024-cycle fill.
